// File: rtl/qeciphy_fault_notifier.sv
// -----------------------------------------------------------------------------
// qeciphy_fault_notifier
//
// Transmit-side fault notifier. When the latched fatal fault from the error
// handler is seen, the 4-bit error code is captured and a 64-bit notification
// word is sent REPEAT_COUNT times to the link partner over a valid/ready
// stream. Consecutive copies are separated by GAP_CYCLES idle cycles.
//
// Word layout:
//   [63:48] 16'hFA17 marker
//   [47:44] captured error code
//   [43:40] sequence index 0..REPEAT_COUNT-1
//   [39:8]  zero
//   [7:0]   CRC-8 (poly 0x07, init 0, MSB first over [63:8]) when
//           QECIPHY_FAULT_NOTIFY_CRC_EN is defined, otherwise 8'h00
//
// Optional feature macro: QECIPHY_FAULT_NOTIFY_CRC_EN
//
// Parameters:
//   REPEAT_COUNT  words per fault event (1..16)
//   GAP_CYCLES    idle cycles between consecutive words (0..65535)
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   fault_fatal_i  latched fatal fault from the error handler
//   ecode_i        latched error code, valid while fault_fatal_i is high
//   tx_tdata_o     notification word
//   tx_tvalid_o    word valid
//   tx_tready_i    TX datapath accepts word
//   notify_busy_o  sequence in progress (SEND or GAP)
//   notify_done_o  all words of the current fault event accepted
// -----------------------------------------------------------------------------
module qeciphy_fault_notifier #(
  parameter int REPEAT_COUNT = 4,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        fault_fatal_i,
  input  logic [3:0]  ecode_i,
  output logic [63:0] tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        notify_busy_o,
  output logic        notify_done_o
);

  localparam logic [3:0]  LAST_SEQ = 4'(REPEAT_COUNT - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);
  localparam logic [15:0] MARKER   = 16'hFA17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t       r_state;
  logic [3:0]   r_ecode;
  logic [3:0]   r_seq;
  logic [15:0]  r_gap_cnt;
  logic [63:0]  r_tdata;
  logic         r_tvalid;
  logic         r_busy;
  logic         r_done;

  logic         w_hs;
  logic [3:0]   w_seq_nxt;

  assign w_hs      = r_tvalid & tx_tready_i;
  assign w_seq_nxt = r_seq + 4'd1;

`ifdef QECIPHY_FAULT_NOTIFY_CRC_EN
  // Serial CRC-8 (x^8 + x^2 + x + 1), message fed MSB first.
  function automatic logic [7:0] crc8(input logic [55:0] msg);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 55; i >= 0; i--) begin
      fb = c[7] ^ msg[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  function automatic logic [63:0] build_word(input logic [3:0] ec,
                                             input logic [3:0] seq);
    logic [55:0] body;
    body = {MARKER, ec, seq, 32'h0000_0000};
`ifdef QECIPHY_FAULT_NOTIFY_CRC_EN
    return {body, crc8(body)};
`else
    return {body, 8'h00};
`endif
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_ecode   <= 4'h0;
      r_seq     <= 4'h0;
      r_gap_cnt <= 16'h0000;
      r_tdata   <= 64'h0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fault_fatal_i) begin
            // Capture straight from ecode_i so the first word is presented
            // on the very next cycle.
            r_ecode  <= ecode_i;
            r_seq    <= 4'h0;
            r_tdata  <= build_word(ecode_i, 4'h0);
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_hs) begin
            if (r_seq == LAST_SEQ) begin
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_seq   <= w_seq_nxt;
              // Next word is prepared now; it only becomes visible to the
              // sink once tvalid is raised again.
              r_tdata <= build_word(r_ecode, w_seq_nxt);
              if (GAP_CYCLES > 0) begin
                r_tvalid  <= 1'b0;
                r_gap_cnt <= GAP_LOAD;
                r_state   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          // Counter holds the number of idle cycles still to elapse including
          // the current one; tvalid rises on the edge that ends the last one.
          if (r_gap_cnt <= 16'd1) begin
            r_gap_cnt <= 16'h0000;
            r_tvalid  <= 1'b1;
            r_state   <= ST_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end

        ST_DONE: begin
          if (!fault_fatal_i) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_tvalid <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_tdata_o    = r_tdata;
  assign tx_tvalid_o   = r_tvalid;
  assign notify_busy_o = r_busy;
  assign notify_done_o = r_done;

endmodule

// File: tb/tb_qeciphy_fault_notifier.sv
// -----------------------------------------------------------------------------
// Bench for qeciphy_fault_notifier. Three instances with different
// REPEAT_COUNT/GAP_CYCLES settings are driven one at a time. Each fault event
// is checked against an event-level model: the ordered list of expected words,
// the required idle gap after every accepted word, and the done/busy status
// after the final acceptance. Ready, fault and ecode are randomised where the
// design must ignore them.
// -----------------------------------------------------------------------------
module tb_qeciphy_fault_notifier;

  localparam int ND = 3;
  localparam int RC_A = 4, GC_A = 16;
  localparam int RC_B = 3, GC_B = 0;
  localparam int RC_C = 2, GC_C = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fault  [ND];
  logic [3:0]  ecode  [ND];
  logic        ready  [ND];
  logic [63:0] tdata  [ND];
  logic        tvalid [ND];
  logic        busy   [ND];
  logic        done   [ND];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qeciphy_fault_notifier #(.REPEAT_COUNT(RC_A), .GAP_CYCLES(GC_A)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .fault_fatal_i(fault[0]), .ecode_i(ecode[0]),
    .tx_tdata_o(tdata[0]), .tx_tvalid_o(tvalid[0]), .tx_tready_i(ready[0]),
    .notify_busy_o(busy[0]), .notify_done_o(done[0]));

  qeciphy_fault_notifier #(.REPEAT_COUNT(RC_B), .GAP_CYCLES(GC_B)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .fault_fatal_i(fault[1]), .ecode_i(ecode[1]),
    .tx_tdata_o(tdata[1]), .tx_tvalid_o(tvalid[1]), .tx_tready_i(ready[1]),
    .notify_busy_o(busy[1]), .notify_done_o(done[1]));

  qeciphy_fault_notifier #(.REPEAT_COUNT(RC_C), .GAP_CYCLES(GC_C)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .fault_fatal_i(fault[2]), .ecode_i(ecode[2]),
    .tx_tdata_o(tdata[2]), .tx_tvalid_o(tvalid[2]), .tx_tready_i(ready[2]),
    .notify_busy_o(busy[2]), .notify_done_o(done[2]));

  function automatic int rc(input int d);
    case (d)
      0:       return RC_A;
      1:       return RC_B;
      default: return RC_C;
    endcase
  endfunction

  function automatic int gc(input int d);
    case (d)
      0:       return GC_A;
      1:       return GC_B;
      default: return GC_C;
    endcase
  endfunction

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [55:0] msg);
    logic [63:0] v;
    v = {msg, 8'h00};
    for (int b = 63; b >= 8; b--) begin
      if (v[b]) v = v ^ (64'h107 << (b - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [63:0] mk_word(input logic [3:0] ec, input int idx);
    logic [63:0] w;
    w = {16'hFA17, ec, 4'(idx), 32'h0, 8'h00};
`ifdef QECIPHY_FAULT_NOTIFY_CRC_EN
    w[7:0] = crc_ref(w[63:8]);
`endif
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check_eq($sformatf("d%0d_%s_tdata", d, tag), tdata[d], 64'h0);
    check_eq($sformatf("d%0d_%s_tvalid", d, tag), 64'(tvalid[d]), 64'h0);
    check_eq($sformatf("d%0d_%s_busy", d, tag), 64'(busy[d]), 64'h0);
    check_eq($sformatf("d%0d_%s_done", d, tag), 64'(done[d]), 64'h0);
  endtask

  // Called at a negedge with the instance idle. Raises the fault and follows
  // the whole notification event. bp_word: word index that sees 10 cycles of
  // forced tready low. rst_word: word index after whose acceptance a reset
  // pulse is applied during the gap (the event is then abandoned).
  task automatic run_seq(input int d, input logic [3:0] ec, input int rdy_pct,
                         input int bp_word, input int rst_word,
                         output bit aborted);
    int r, g, budget, hold;
    bit hs;
    r = rc(d);
    g = gc(d);
    aborted = 1'b0;
    fault[d] = 1'b1;
    ecode[d] = ec;
    ready[d] = 1'b0;
    @(negedge clk);
    check_eq($sformatf("d%0d_lat_busy", d), 64'(busy[d]), 64'h1);
    for (int i = 0; i < r; i++) begin
      hs = 1'b0;
      budget = 0;
      hold = 0;
      while (!hs) begin
        check_eq($sformatf("d%0d_vld_w%0d", d, i), 64'(tvalid[d]), 64'h1);
        check_eq($sformatf("d%0d_data_w%0d", d, i), tdata[d], mk_word(ec, i));
        check_eq($sformatf("d%0d_busy_w%0d", d, i), 64'(busy[d]), 64'h1);
        check_eq($sformatf("d%0d_done_w%0d", d, i), 64'(done[d]), 64'h0);
        if (i == bp_word && hold < 10) begin
          ready[d] = 1'b0;
          hold++;
        end else begin
          ready[d] = ($urandom_range(99) < rdy_pct);
        end
        fault[d] = (i == r - 1) ? 1'b1 : 1'($urandom_range(1));
        ecode[d] = 4'($urandom_range(15));
        hs = ready[d];
        @(negedge clk);
        budget++;
        if (!hs && budget >= 300) begin
          n_chk++;
          n_bad++;
          $display("FAIL d%0d_hs_timeout word=%0d got=no_handshake exp=handshake", d, i);
          return;
        end
      end
      if (i < r - 1) begin
        for (int k = 0; k < g; k++) begin
          check_eq($sformatf("d%0d_gap_vld_w%0d_k%0d", d, i, k), 64'(tvalid[d]), 64'h0);
          check_eq($sformatf("d%0d_gap_busy_w%0d_k%0d", d, i, k), 64'(busy[d]), 64'h1);
          if (i == rst_word && k == 3) begin
            #2 rst_n = 1'b0;
            #1;
            for (int dd = 0; dd < ND; dd++) check_zero(dd, "rst_async");
            @(negedge clk);
            check_zero(d, "rst_held");
            rst_n = 1'b1;
            fault[d] = 1'b1;
            ecode[d] = ec;
            aborted = 1'b1;
            return;
          end
          ready[d] = 1'($urandom_range(1));
          fault[d] = 1'($urandom_range(1));
          ecode[d] = 4'($urandom_range(15));
          @(negedge clk);
        end
      end else begin
        check_eq($sformatf("d%0d_end_vld", d), 64'(tvalid[d]), 64'h0);
        check_eq($sformatf("d%0d_end_busy", d), 64'(busy[d]), 64'h0);
        check_eq($sformatf("d%0d_end_done", d), 64'(done[d]), 64'h1);
      end
    end
  endtask

  // Holds DONE for a while, then drops the fault for one cycle.
  task automatic done_exit(input int d);
    repeat (2) begin
      ready[d] = 1'($urandom_range(1));
      ecode[d] = 4'($urandom_range(15));
      @(negedge clk);
      check_eq($sformatf("d%0d_hold_done", d), 64'(done[d]), 64'h1);
      check_eq($sformatf("d%0d_hold_vld", d), 64'(tvalid[d]), 64'h0);
      check_eq($sformatf("d%0d_hold_busy", d), 64'(busy[d]), 64'h0);
    end
    fault[d] = 1'b0;
    @(negedge clk);
    check_eq($sformatf("d%0d_exit_done", d), 64'(done[d]), 64'h0);
    check_eq($sformatf("d%0d_exit_vld", d), 64'(tvalid[d]), 64'h0);
    check_eq($sformatf("d%0d_exit_busy", d), 64'(busy[d]), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    int d;
    rst_n = 1'b0;
    for (int i = 0; i < ND; i++) begin
      fault[i] = 1'b0;
      ecode[i] = 4'h0;
      ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) check_zero(i, "reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ND; i++) check_zero(i, "post_release");

    // Basic 4 words, 16-cycle gaps, full ready, ecode 5.
    run_seq(0, 4'h5, 100, -1, -1, ab);
    done_exit(0);

    // Backpressure on word 1.
    run_seq(0, 4'h5, 100, 1, -1, ab);
    done_exit(0);

    // Reset pulse during the gap after word 1, then fresh restart.
    run_seq(0, 4'h5, 100, -1, 1, ab);
    run_seq(0, 4'h5, 100, -1, -1, ab);
    done_exit(0);

    // New event with a different code after leaving DONE.
    run_seq(0, 4'h3, 100, -1, -1, ab);
    done_exit(0);

    // Back-to-back words (no gap).
    run_seq(1, 4'h9, 100, -1, -1, ab);
    done_exit(1);

    // Two words, single-cycle gap, ecode A.
    run_seq(2, 4'hA, 100, -1, -1, ab);
    done_exit(2);

    // Zero error code is still sent.
    run_seq(1, 4'h0, 100, -1, -1, ab);
    done_exit(1);

    // Randomised events with random backpressure.
    for (int t = 0; t < 12; t++) begin
      d = t % ND;
      run_seq(d, 4'($urandom_range(15)), 30 + int'($urandom_range(70)), -1, -1, ab);
      done_exit(d);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
